// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-stage valid tracking, stall/flush/enable generation for
// memory back-pressure, taken branches and load-use hazards, plus saturating event counters.
module pipeline_ctrl #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  input  logic                  counter_clr,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [NUM_STAGES-1:0] stage_enable,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  load_next_pc,
  output logic                  pc_sel_branch,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int MemIdx = int'(NUM_STAGES) - 2;
  localparam int WbIdx  = int'(NUM_STAGES) - 1;

  logic [NUM_STAGES-1:0] stage_valid_q, stage_valid_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;
  logic [CNT_W-1:0]      flush_count_q, flush_count_d;

  logic hold_mem, branch_act, load_use;
  logic rs1_hit, rs2_hit;

  // Hazard detection; every event is gated by the valid bit of the stage that raises it.
  always_comb begin
    hold_mem   = mem_busy & stage_valid_q[MemIdx];
    branch_act = branch_taken & stage_valid_q[2] & ~hold_mem;
    rs1_hit    = id_uses_rs1 & (id_rs1 == ex_rd);
    rs2_hit    = id_uses_rs2 & (id_rs2 == ex_rd);
    load_use   = stage_valid_q[1] & stage_valid_q[2] & ex_mem_read & (ex_rd != '0) &
                 (rs1_hit | rs2_hit) & ~branch_act & ~hold_mem;
  end

  // Pipeline register control and next valid state, priority hold_mem > branch > load-use.
  always_comb begin
    stage_enable  = '1;
    flush         = '0;
    load_next_pc  = 1'b1;
    pc_sel_branch = 1'b0;
    stage_valid_d = {stage_valid_q[NUM_STAGES-2:0], fetch_valid};
    if (hold_mem) begin
      // Freeze everything up to MEM; WB drains into a bubble.
      for (int i = 0; i <= MemIdx; i++) begin
        stage_enable[i] = 1'b0;
      end
      stage_valid_d        = stage_valid_q;
      stage_valid_d[WbIdx] = 1'b0;
      flush[WbIdx]         = 1'b1;
      load_next_pc         = 1'b0;
    end else if (branch_act) begin
      // Kill the wrong-path fetches in IF and ID; redirect the PC.
      flush[1:0]         = 2'b11;
      stage_valid_d[1:0] = 2'b00;
      pc_sel_branch      = 1'b1;
    end else if (load_use) begin
      // Hold IF/ID one cycle and insert a bubble into EX.
      stage_enable[1:0]  = 2'b00;
      stage_valid_d[1:0] = stage_valid_q[1:0];
      stage_valid_d[2]   = 1'b0;
      flush[2]           = 1'b1;
      load_next_pc       = 1'b0;
    end
  end

  // Saturating event counters; clear has priority over increment.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (counter_clr) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if ((hold_mem | load_use) && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + CNT_W'(1);
      end
      if (branch_act && (flush_count_q != '1)) begin
        flush_count_d = flush_count_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid_q <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stage_valid = stage_valid_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of pipeline stages (legal 5..8; stage 0 = IF, 1 = ID, 2 = EX, MEM = NUM_STAGES-2, WB = NUM_STAGES-1).
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-003 SHALL have parameter CNT_W, default 16, event-counter width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 fetch_valid  in  1  fetch unit presents an instruction this cycle.
REQ-008 id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
REQ-009 id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2.
REQ-010 ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
REQ-011 ex_mem_read  in  1  EX instruction is a load.
REQ-012 branch_taken  in  1  EX resolved a taken branch/jump.
REQ-013 mem_busy  in  1  data memory not ready for the MEM-stage access.
REQ-014 counter_clr  in  1  synchronous clear of both counters.
REQ-015 stage_valid  out  NUM_STAGES  registered valid bit per stage.
REQ-016 stage_enable  out  NUM_STAGES  combinational load enable per stage pipeline register.
REQ-017 flush  out  NUM_STAGES  combinational; bit i = stage i loads a bubble this cycle.
REQ-018 load_next_pc  out  1  combinational; PC register updates this cycle.
REQ-019 pc_sel_branch  out  1  combinational; next PC = branch target.
REQ-020 stall_count, flush_count  out  CNT_W  saturating event counters.

Function
REQ-021 Definitions: hold_mem = mem_busy & stage_valid[MEM]; branch_act = branch_taken & stage_valid[2] & ~hold_mem; load_use = stage_valid[1] & stage_valid[2] & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)) & ~branch_act & ~hold_mem.
REQ-022 Priority SHALL be hold_mem > branch_act > load_use > normal advance.
REQ-023 Normal: all stage_enable = 1; stage_valid[0] <= fetch_valid; stage_valid[i] <= stage_valid[i-1]; flush = 0; load_next_pc = 1; pc_sel_branch = 0.
REQ-024 hold_mem: stages 0..MEM SHALL hold (enable 0, valid unchanged); stage WB loads bubble (enable 1, flush[WB] = 1, valid 0); load_next_pc = 0; branch_taken ignored.
REQ-025 branch_act: stages 0 and 1 load bubbles (flush[0], flush[1] = 1, valid 0); stages 2..N-1 advance; load_next_pc = 1; pc_sel_branch = 1; fetch_valid ignored that cycle.
REQ-026 load_use: stages 0, 1 hold; stage 2 loads bubble (flush[2] = 1); stages 3..N-1 advance; load_next_pc = 0.
REQ-027 Latency: an instruction entering stage 0 with no events SHALL reach WB after NUM_STAGES-1 cycles; load_use adds exactly 1 cycle; hold_mem adds 1 cycle per busy cycle.
REQ-028 stall_count SHALL increment by 1 per cycle with hold_mem or load_use; flush_count by 1 per branch_act cycle.
REQ-029 Counters SHALL saturate at 2^CNT_W-1 (no wrap); counter_clr sets both to 0 and wins over increment in the same cycle.
REQ-030 Invalid stages SHALL never trigger events (gated by stage_valid per REQ-021).

Reset
REQ-031 rst low SHALL asynchronously clear stage_valid, stall_count, flush_count to 0.
REQ-032 During reset all combinational outputs SHALL follow REQ-023 from the cleared state; events are impossible since all valids are 0.
REQ-033 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state; first cycle after release is normal advance.

Verification
REQ-034 NUM_STAGES=5, fetch_valid=1 constant after reset -> stage_valid 00001, 00011, ... 11111 over 5 cycles; counters 0.
REQ-035 Load in EX with ex_rd=5, ID id_rs1=5 used -> one cycle flush=00100, load_next_pc=0, stall_count=1; next cycle normal; ex_rd=0 same case -> no stall.
REQ-036 branch_taken=1 with stage_valid[2]=1 and simultaneous load_use -> flush=00011, pc_sel_branch=1, flush_count=1, stall_count unchanged.
REQ-037 mem_busy=1 for 3 cycles with MEM valid plus branch_taken=1 -> stages 0..3 frozen 3 cycles, flush[4]=1 each, stall_count=3; branch acted in first non-busy cycle.
REQ-038 CNT_W=4, 20 load-use stalls -> stall_count holds at 15; counter_clr with active stall -> 0.
REQ-039 rst pulsed low mid hold_mem -> stage_valid=0 and counters=0 immediately, no clk edge needed.
